eth_frame_gen: RTL and testbench
================================

// Module: eth_frame_gen
// PURPOSE
//  Synthesisable Ethernet frame generator. Replaces the fixed-width, fixed-length bench task as the FIFO/ACL stimulus source.
//  Emits one frame per start: header (dest MAC, src MAC, EtherType), then payload, then zero padding to 60 bytes (FCS excluded).
//  Output is an AXI-Stream master with tready backpressure and tkeep; it feeds the FIFO rx port.
// PARAMETERS
//  DATA_W       32    stream width in bits; multiple of 8, range 8..64; BPW = DATA_W/8 bytes per word
//  MAX_PAYLOAD  1500  payload length clamp, in bytes
//  CNT_W        16    width of the frame counter
// PORTS
//  clk               in   1        system clock
//  i_rst             in   1        synchronous reset, active-high
//  i_start           in   1        one-cycle pulse; begins a frame when idle
//  i_dest_mac        in   48       destination MAC
//  i_src_mac         in   48       source MAC
//  i_ether_type      in   16       EtherType
//  i_payload_len     in   11       requested payload bytes (0..2047)
//  i_pattern         in   2        0 = incrementing (i%256), 1 = constant i_fill_byte, 2 = LFSR, 3 = reserved (treated as 0)
//  i_fill_byte       in   8        constant fill value / LFSR seed (0 seeds as 8'h01)
//  o_txd_tdata       out  DATA_W   byte 0 of the beat in MSBs
//  o_txd_tkeep       out  DATA_W/8 MSB-aligned byte-valid mask
//  o_txd_tvalid      out  1        beat valid
//  o_txd_tlast       out  1        last beat of the frame
//  i_txd_tready      in   1        sink ready
//  o_busy            out  1        high from the accepted start until the last beat is transferred
//  o_done            out  1        one-cycle pulse after the last beat is transferred
//  o_frame_cnt       out  CNT_W    count of completed frames; wraps
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; LFSR reseeds on the next start.
//  - FSM states: IDLE -> SEND -> DONE -> IDLE.
//  - IDLE: on i_start, latch all config inputs. Set PLEN = min(i_payload_len, MAX_PAYLOAD).
//    Set FLEN = 14 + max(PLEN, 46). Go to SEND. First tvalid appears the next cycle (latency 1).
//  - SEND: the beat carries frame bytes b..b+BPW-1. Advance b by BPW only when tvalid && tready.
//    tdata, tkeep and tlast stay stable while tvalid && !tready.
//  - Byte k: bytes 0-5 are dest MAC (MSB first), 6-11 src MAC, 12-13 EtherType.
//    For p = k-14: p < PLEN gives the pattern byte; PLEN <= p < FLEN gives 8'h00.
//  - LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Step once per payload byte, unrolled BPW per beat.
//    Padding does not step it.
//  - Last beat: tlast = 1. tkeep ones = FLEN mod BPW, or all ones if that is 0. Unused bytes are 8'h00.
//    All other beats have tkeep all ones.
//  - DONE (one cycle): o_done = 1, o_frame_cnt += 1, o_busy = 0, tvalid = 0. Then go to IDLE.
//  - i_start is ignored while in SEND or DONE.
//  - i_rst mid-frame: outputs are 0 on the next edge, with no tlast, no done and no count increment.
//  - i_payload_len > MAX_PAYLOAD is clamped silently. 0 produces 46 padding bytes.
// STRUCTURE
//  - Package eth_frame_pkg: HEADER_SIZE=14, MIN_PAYLOAD=46, MIN_FRAME=60, pattern_e enum, lfsr8_next() function.
//  - Sub-module eth_byte_src: combinational. Given byte index, latched header fields, pattern and LFSR state,
//    it returns the BPW bytes of a beat and the next LFSR state.
//  - Top: FSM, byte counter (11 bits), tkeep/tlast generation, frame counter.
// TESTING
//  1. DATA_W=32, payload 1500, pattern 0, tready=1 -> 379 beats.
//     Beats 0-3: 0x00142201, 0x23450014, 0x226789AB, 0x08000001. Last tkeep 4'b1100, tlast only there, o_done once.
//  2. DATA_W=32, payload 10 -> 15 beats, 60 bytes total. Bytes 24..59 are 0x00. Last tkeep 4'b1111.
//  3. payload 1500 with tready toggled 1/0 each cycle -> same 379-beat byte stream.
//     tdata, tkeep and tlast are stable across every stall cycle.
//  4. i_start pulsed again at beat 5, then i_rst at beat 100 -> second start ignored.
//     After reset tvalid=0, o_frame_cnt=0, no o_done. The next start produces a complete, correct frame.
//  5. DATA_W=64, payload 1500 -> 190 beats, last tkeep 8'hC0. payload 2000 -> clamped, identical output.
//  6. pattern 1 with fill 0xA5, payload 46 -> payload bytes all 0xA5.
//     pattern 2 with seed 0 -> first payload byte is lfsr8_next(8'h01). o_frame_cnt increments by 1 per frame.

Source files
------------

// File: rtl/eth_frame_pkg.sv
// eth_frame_pkg: shared constants, types and LFSR step for the Ethernet frame generator
package eth_frame_pkg;
  localparam int HEADER_SIZE = 14;
  localparam int MIN_PAYLOAD = 46;
  localparam int MIN_FRAME = 60;
  typedef enum logic [1:0] {PAT_INC, PAT_CONST, PAT_LFSR, PAT_RSVD} pattern_e;
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    pattern_e    pattern;
    logic [7:0]  fill;
    logic [10:0] plen;
    logic [10:0] flen;
  } cfg_t;
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
endpackage

// File: rtl/eth_byte_src.sv
// eth_byte_src: combinational source of one beat of frame bytes plus the LFSR state after it
module eth_byte_src
  import eth_frame_pkg::*;
#(
  parameter int BPW = 4
) (
  input  logic [111:0]     i_hdr,
  input  pattern_e         i_pattern,
  input  logic [7:0]       i_fill,
  input  logic [10:0]      i_plen,
  input  logic [10:0]      i_idx,
  input  logic [7:0]       i_lfsr,
  output logic [8*BPW-1:0] o_data,
  output logic [7:0]       o_lfsr
);
  logic [10:0] k, p;
  always_comb begin
    o_data = '0;
    o_lfsr = i_lfsr;
    k = '0;
    p = '0;
    for (int j = 0; j < BPW; j++) begin
      k = i_idx + 11'(j);
      p = k - 11'(HEADER_SIZE);
      if (k < 11'(HEADER_SIZE)) o_data[8*(BPW-1-j) +: 8] = i_hdr[111 - 8*int'(k) -: 8];
      else if (p < i_plen) begin
        o_lfsr = lfsr8_next(o_lfsr);
        o_data[8*(BPW-1-j) +: 8] = i_pattern == PAT_CONST ? i_fill : i_pattern == PAT_LFSR ? o_lfsr : p[7:0];
      end
    end
  end
endmodule

// File: rtl/eth_frame_gen.sv
// eth_frame_gen: AXI-Stream Ethernet frame generator with header, patterned payload and zero padding
module eth_frame_gen
  import eth_frame_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MAX_PAYLOAD = 1500,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [47:0]         i_dest_mac,
  input  logic [47:0]         i_src_mac,
  input  logic [15:0]         i_ether_type,
  input  logic [10:0]         i_payload_len,
  input  logic [1:0]          i_pattern,
  input  logic [7:0]          i_fill_byte,
  output logic [DATA_W-1:0]   o_txd_tdata,
  output logic [DATA_W/8-1:0] o_txd_tkeep,
  output logic                o_txd_tvalid,
  output logic                o_txd_tlast,
  input  logic                i_txd_tready,
  output logic                o_busy,
  output logic                o_done,
  output logic [CNT_W-1:0]    o_frame_cnt
);
  localparam int BPW = DATA_W / 8;
  state_e state_q, state_d;
  cfg_t cfg_q, cfg_d;
  logic [10:0] idx_q, idx_d, plen, rem;
  logic [7:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] beat;
  logic last;
  eth_byte_src #(.BPW(BPW)) u_src (
    .i_hdr    ({cfg_q.dest, cfg_q.src, cfg_q.etype}),
    .i_pattern(cfg_q.pattern),
    .i_fill   (cfg_q.fill),
    .i_plen   (cfg_q.plen),
    .i_idx    (idx_q),
    .i_lfsr   (lfsr_q),
    .o_data   (beat),
    .o_lfsr   (lfsr_nxt)
  );
  assign plen = i_payload_len > 11'(MAX_PAYLOAD) ? 11'(MAX_PAYLOAD) : i_payload_len;
  assign rem = cfg_q.flen - idx_q;
  assign last = rem <= 11'(BPW);
  assign o_frame_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    cfg_d = cfg_q;
    idx_d = idx_q;
    lfsr_d = lfsr_q;
    cnt_d = cnt_q;
    o_txd_tvalid = state_q == SEND;
    o_txd_tlast = o_txd_tvalid && last;
    o_txd_tdata = o_txd_tvalid ? beat : '0;
    o_busy = o_txd_tvalid;
    o_done = state_q == DONE;
    o_txd_tkeep = '0;
    for (int j = 0; j < BPW; j++) o_txd_tkeep[BPW-1-j] = o_txd_tvalid && 11'(j) < rem;
    if (state_q == IDLE && i_start) begin
      state_d = SEND;
      cfg_d = '{dest: i_dest_mac, src: i_src_mac, etype: i_ether_type, pattern: pattern_e'(i_pattern),
                fill: i_fill_byte, plen: plen,
                flen: plen < 11'(MIN_PAYLOAD) ? 11'(MIN_FRAME) : 11'(HEADER_SIZE) + plen};
      idx_d = '0;
      lfsr_d = i_fill_byte == 8'h00 ? 8'h01 : i_fill_byte;
    end
    if (o_txd_tvalid && i_txd_tready) begin
      idx_d = idx_q + 11'(BPW);
      lfsr_d = lfsr_nxt;
      state_d = last ? DONE : SEND;
    end
    if (o_done) begin
      state_d = IDLE;
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cfg_q <= '0;
      idx_q <= '0;
      lfsr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_q <= cfg_d;
      idx_q <= idx_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_eth_frame_gen.sv
// tb_eth_frame_gen: model-based checking of 32- and 64-bit frame generators driven in parallel
module tb_eth_frame_gen;
  logic clk = 0, i_rst = 1, i_start = 0, rdy = 1;
  logic [47:0] dest = 48'h001422012345, src = 48'h0014226789AB;
  logic [15:0] etype = 16'h0800;
  logic [10:0] plen_in = '0;
  logic [1:0] pat_in = '0;
  logic [7:0] fill_in = '0;
  logic [31:0] d32;
  logic [3:0] k32;
  logic v32, l32, b32, dn32;
  logic [15:0] c32;
  logic [63:0] d64;
  logic [7:0] k64;
  logic v64, l64, b64, dn64;
  logic [15:0] c64;
  int n_checks = 0, n_fail = 0, exp_frames = 0;
  int pos32, pos64, ndone32, ndone64, exp_len;
  logic [7:0] exp_b [0:2047];
  logic [31:0] q32 [$];
  logic [63:0] q64 [$];
  logic [3:0] lk32;
  logic [7:0] lk64;

  always #5 clk = ~clk;

  eth_frame_gen #(.DATA_W(32)) u32 (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_dest_mac(dest), .i_src_mac(src),
    .i_ether_type(etype), .i_payload_len(plen_in), .i_pattern(pat_in), .i_fill_byte(fill_in),
    .o_txd_tdata(d32), .o_txd_tkeep(k32), .o_txd_tvalid(v32), .o_txd_tlast(l32),
    .i_txd_tready(rdy), .o_busy(b32), .o_done(dn32), .o_frame_cnt(c32));
  eth_frame_gen #(.DATA_W(64)) u64 (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_dest_mac(dest), .i_src_mac(src),
    .i_ether_type(etype), .i_payload_len(plen_in), .i_pattern(pat_in), .i_fill_byte(fill_in),
    .o_txd_tdata(d64), .o_txd_tkeep(k64), .o_txd_tvalid(v64), .o_txd_tlast(l64),
    .i_txd_tready(rdy), .o_busy(b64), .o_done(dn64), .o_frame_cnt(c64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_ref(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic build(input int len, input int pat, input logic [7:0] fill);
    int pl;
    logic [7:0] st;
    pl = len > 1500 ? 1500 : len;
    exp_len = 14 + (pl < 46 ? 46 : pl);
    st = fill == 0 ? 8'h01 : fill;
    for (int k = 0; k < 6; k++) begin
      exp_b[k] = dest[47-8*k -: 8];
      exp_b[k+6] = src[47-8*k -: 8];
    end
    exp_b[12] = etype[15:8];
    exp_b[13] = etype[7:0];
    for (int p = 0; p < exp_len - 14; p++) begin
      if (p >= pl) exp_b[p+14] = 8'h00;
      else if (pat == 1) exp_b[p+14] = fill;
      else if (pat == 2) begin
        st = lfsr_ref(st);
        exp_b[p+14] = st;
      end else exp_b[p+14] = 8'(p % 256);
    end
  endtask

  task automatic cmp_beat(input string name, input int bpw, input logic [63:0] d, input logic [7:0] k,
                          input logic l, input int pos);
    logic [63:0] ed;
    logic [7:0] ek;
    ed = '0;
    ek = '0;
    if (pos >= exp_len) begin
      chk({name, "_extra_beat"}, 64'(pos), 64'(exp_len));
      return;
    end
    for (int j = 0; j < bpw; j++)
      if (pos + j < exp_len) begin
        ed[63-8*j -: 8] = exp_b[pos+j];
        ek[7-j] = 1'b1;
      end
    chk({name, "_data"}, d, ed);
    chk({name, "_keep"}, 64'(k), 64'(ek));
    chk({name, "_last"}, 64'(l), 64'(pos + bpw >= exp_len));
  endtask

  always @(negedge clk) begin
    if (!i_rst) begin
      if (v32) begin
        cmp_beat("beat32", 4, {d32, 32'h0}, {k32, 4'h0}, l32, pos32);
        if (rdy) begin
          q32.push_back(d32);
          lk32 = k32;
          pos32 += 4;
        end
      end
      if (v64) begin
        cmp_beat("beat64", 8, d64, k64, l64, pos64);
        if (rdy) begin
          q64.push_back(d64);
          lk64 = k64;
          pos64 += 8;
        end
      end
      if (dn32) ndone32++;
      if (dn64) ndone64++;
    end
  end

  task automatic run(input int len, input int pat, input logic [7:0] fill, input bit tog,
                     input int dup_at, input int rst_at);
    int cyc;
    build(len, pat, fill);
    pos32 = 0;
    pos64 = 0;
    ndone32 = 0;
    ndone64 = 0;
    q32.delete();
    q64.delete();
    plen_in = 11'(len);
    pat_in = 2'(pat);
    fill_in = fill;
    rdy = 1;
    i_start = 1;
    @(posedge clk);
    #1;
    i_start = 0;
    chk("busy32_after_start", 64'(b32), 64'd1);
    chk("valid64_latency1", 64'(v64), 64'd1);
    cyc = 0;
    while (!(ndone32 > 0 && ndone64 > 0) && cyc < 5000) begin
      if (cyc == rst_at) begin
        i_rst = 1;
        @(posedge clk);
        #1;
        i_rst = 0;
        break;
      end
      i_start = cyc == dup_at;
      plen_in = cyc == dup_at ? 11'd5 : 11'(len);
      pat_in = cyc == dup_at ? 2'd1 : 2'(pat);
      rdy = tog ? ~rdy : 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    i_start = 0;
    plen_in = 11'(len);
    pat_in = 2'(pat);
    rdy = 1;
    if (cyc >= 5000) chk("frame_timeout", 64'(cyc), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    if (rst_at < 0) begin
      exp_frames++;
      chk("done32_once", 64'(ndone32), 64'd1);
      chk("done64_once", 64'(ndone64), 64'd1);
      chk("cnt32", 64'(c32), 64'(exp_frames));
      chk("cnt64", 64'(c64), 64'(exp_frames));
      chk("busy32_idle", 64'(b32), 64'd0);
      chk("bytes32", 64'(pos32 >= exp_len && pos32 < exp_len + 4), 64'd1);
      chk("bytes64", 64'(pos64 >= exp_len && pos64 < exp_len + 8), 64'd1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data32", 64'(d32), 64'd0);
    chk("rst_ctrl32", 64'({k32, v32, l32, b32, dn32, c32}), 64'd0);
    chk("rst_ctrl64", 64'({k64, v64, l64, b64, dn64, c64}), 64'd0);
    i_rst = 0;
    @(posedge clk);
    #1;
    run(1500, 0, 8'h00, 0, -1, -1);
    chk("t1_beat0", 64'(q32[0]), 64'h00142201);
    chk("t1_beat1", 64'(q32[1]), 64'h23450014);
    chk("t1_beat2", 64'(q32[2]), 64'h226789AB);
    chk("t1_beat3", 64'(q32[3]), 64'h08000001);
    chk("t1_nbeats32", 64'(q32.size()), 64'd379);
    chk("t1_lastkeep32", 64'(lk32), 64'hC);
    run(10, 0, 8'h00, 0, -1, -1);
    chk("t2_nbeats32", 64'(q32.size()), 64'd15);
    chk("t2_lastkeep32", 64'(lk32), 64'hF);
    chk("t2_lastbeat", 64'(q32[14]), 64'h0);
    chk("t2_beat6", 64'(q32[6]), 64'h00000000);
    run(1500, 0, 8'h00, 1, -1, -1);
    chk("t3_nbeats32", 64'(q32.size()), 64'd379);
    run(1500, 0, 8'h00, 0, 5, 100);
    chk("t4_valid32_after_rst", 64'(v32), 64'd0);
    chk("t4_valid64_after_rst", 64'(v64), 64'd0);
    chk("t4_cnt32_after_rst", 64'(c32), 64'd0);
    chk("t4_cnt64_after_rst", 64'(c64), 64'd0);
    chk("t4_no_done", 64'(ndone32 + ndone64), 64'd0);
    exp_frames = 0;
    run(1500, 0, 8'h00, 0, -1, -1);
    chk("t4_nbeats32_after", 64'(q32.size()), 64'd379);
    chk("t5_nbeats64", 64'(q64.size()), 64'd190);
    chk("t5_lastkeep64", 64'(lk64), 64'hC0);
    run(2000, 0, 8'h00, 0, -1, -1);
    chk("t5_clamp_nbeats64", 64'(q64.size()), 64'd190);
    chk("t5_clamp_lastkeep64", 64'(lk64), 64'hC0);
    chk("t5_clamp_beat0_64", q64[0], 64'h0014220123450014);
    run(46, 1, 8'hA5, 0, -1, -1);
    chk("t6_fill_beat3", 64'(q32[3]), 64'h0800A5A5);
    chk("t6_fill_beat4", 64'(q32[4]), 64'hA5A5A5A5);
    run(100, 2, 8'h00, 0, -1, -1);
    chk("t6_lfsr_beat3", 64'(q32[3]), 64'h08000204);
    chk("t6_frame_cnt", 64'(c32), 64'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
